// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level and the
// bit-period computation that the transmitter and the future receiver use.
package uart_pkg;

   // Transmit FSM states. PARITY is only reached in UART_TX_PARITY_EN builds.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } uart_state_t;

   // Level of an idle (marking) line; also the stop-bit level.
   localparam logic LINE_IDLE = 1'b1;

   // Clock cycles per bit, truncating division. Result must be at least 2.
   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: counts 0..CLKS_PER_BIT-1 and flags the last cycle
// of every bit period. Holding clear keeps the count at zero, so the first
// period after clear drops is a full CLKS_PER_BIT cycles long.
import uart_pkg::*;

module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // Bit-period counter; wraps to zero at each bit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || (cnt == CNT_MAX)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bit_tick = !clear && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Pops one byte from the upstream FIFO per frame (read data
// arrives one cycle after the pop strobe) and shifts it out LSB first as
// start, DATA_WIDTH data bits, optional even parity, STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit.
import uart_pkg::*;

module uart_tx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

   localparam int unsigned   IDX_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   uart_state_t           state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_shift;
   logic [IDX_W-1:0]      bit_idx;
   logic                  stop_idx;
   logic                  bit_tick;
   logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
   logic                  parity_bit;
`endif

   // Outside the serial states the bit timer is held at zero so START
   // always begins a full bit period.
   assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .bit_tick(bit_tick)
   );

   // Next data bit lines up at bit 0 after shifting.
   always_comb begin
      shreg_shift = shreg >> 1;
   end

   // Frame sequencer: state, shift register, bit/stop counters and tx line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tx         <= LINE_IDLE;
         tx_done    <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state <= ST_LOAD;
            end
            ST_LOAD: begin
               shreg      <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
               parity_bit <= ^fifo_rd_data;
`endif
               tx         <= 1'b0;
               state      <= ST_START;
            end
            ST_START: begin
               if (bit_tick) begin
                  tx      <= shreg[0];
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     tx       <= parity_bit;
                     state    <= ST_PARITY;
`else
                     tx       <= LINE_IDLE;
                     stop_idx <= 1'b0;
                     state    <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shreg_shift;
                     tx      <= shreg_shift[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  tx       <= LINE_IDLE;
                  stop_idx <= 1'b0;
                  state    <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (bit_tick) begin
                  if (stop_idx == STOP_LAST) begin
                     tx_done <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            default: begin
               tx    <= LINE_IDLE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Pop strobe and busy flag decode straight from the state register.
   assign fifo_rd_en = (state == ST_FETCH);
   assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT = 10 and a one-cycle-latency
// FIFO model. Expected line patterns are built from the byte under test.
module tb_uart_tx;

   localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME_LEN = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic [7:0]  mem [0:15];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   int unsigned rd_en_cnt = 0;
   int unsigned done_cnt = 0;
   int unsigned pop_empty_cnt = 0;

   int pass_cnt = 0;
   int check_cnt = 0;

   logic exp_bits [0:10];

   uart_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD      (100_000),
      .DATA_WIDTH(8),
      .STOP_BITS (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty),
      .fifo_rd_data(fifo_rd_data),
      .fifo_rd_en  (fifo_rd_en),
      .tx          (tx),
      .busy        (busy),
      .tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model with registered read port, plus event counters.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_en_cnt <= rd_en_cnt + 1;
         if (wr_ptr == rd_ptr) begin
            pop_empty_cnt <= pop_empty_cnt + 1;
         end else begin
            fifo_rd_data <= mem[rd_ptr % 16];
            rd_ptr       <= rd_ptr + 1;
         end
      end
      if (tx_done) done_cnt <= done_cnt + 1;
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 16] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic build_frame(input logic [7:0] b);
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
      exp_bits[NBITS - 1] = 1'b1;
   endtask

   task automatic test_reset;
      int bad_tx = 0, bad_busy = 0, bad_rd = 0, bad_done = 0;
      rst_n = 1'b0;
      push(8'h3C);
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (fifo_rd_en !== 1'b0) bad_rd++;
         if (tx_done !== 1'b0) bad_done++;
      end
      check_cnt++;
      if (bad_tx !== 0) $display("FAIL reset_tx: %0d cycles tx!=1, required 0", bad_tx);
      else pass_cnt++;
      check_cnt++;
      if (bad_busy !== 0) $display("FAIL reset_busy: %0d cycles busy!=0, required 0", bad_busy);
      else pass_cnt++;
      check_cnt++;
      if (bad_rd !== 0) $display("FAIL reset_rd_en: %0d cycles rd_en!=0, required 0", bad_rd);
      else pass_cnt++;
      check_cnt++;
      if (bad_done !== 0) $display("FAIL reset_tx_done: %0d cycles tx_done!=0, required 0", bad_done);
      else pass_cnt++;
      // drain the model so the block starts idle after release
      wr_ptr = rd_ptr;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte;
      int unsigned r0, d0;
      int n, bad;
      build_frame(8'hA5);
`ifdef UART_TX_PARITY_EN
      exp_bits[9] = 1'b0;
`endif
      r0 = rd_en_cnt;
      d0 = done_cnt;
      push(8'hA5);
      @(negedge clk);   // after edge 1
      check_cnt++;
      if (fifo_rd_en !== 1'b1) $display("FAIL a5_rd_en_edge1: got %b, required 1", fifo_rd_en);
      else pass_cnt++;
      @(negedge clk);   // after edge 2
      check_cnt++;
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1)
         $display("FAIL a5_edge2: rd_en=%b tx=%b, required rd_en=0 tx=1", fifo_rd_en, tx);
      else pass_cnt++;
      @(negedge clk);   // after edge 3
      check_cnt++;
      if (tx !== 1'b0) $display("FAIL a5_tx_fall_edge3: got %b, required 0", tx);
      else pass_cnt++;
      n = 0;
      bad = 0;
      while (tx_done !== 1'b1 && n < 200) begin
         if (n < int'(FRAME_LEN) && tx !== exp_bits[n / CPB]) bad++;
         n++;
         @(negedge clk);
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL a5_pattern: %0d wrong line samples, required 0", bad);
      else pass_cnt++;
      check_cnt++;
      if (n !== int'(FRAME_LEN)) $display("FAIL a5_frame_len: got %0d cycles, required %0d", n, FRAME_LEN);
      else pass_cnt++;
      check_cnt++;
      if (busy !== 1'b0 || tx !== 1'b1)
         $display("FAIL a5_idle_at_done: busy=%b tx=%b, required busy=0 tx=1", busy, tx);
      else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (tx_done !== 1'b0) $display("FAIL a5_done_one_cycle: got %b, required 0", tx_done);
      else pass_cnt++;
      check_cnt++;
      if (rd_en_cnt - r0 !== 1 || done_cnt - d0 !== 1)
         $display("FAIL a5_counts: pops=%0d dones=%0d, required 1 and 1", rd_en_cnt - r0, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_parity;
      int n, bad, wait_n;
      build_frame(8'h07);
`ifdef UART_TX_PARITY_EN
      exp_bits[9] = 1'b1;
`endif
      push(8'h07);
      wait_n = 0;
      while (tx !== 1'b0 && wait_n < 10) begin
         wait_n++;
         @(negedge clk);
      end
      check_cnt++;
      if (wait_n !== 3) $display("FAIL p07_start_latency: got %0d, required 3", wait_n);
      else pass_cnt++;
      n = 0;
      bad = 0;
      while (tx_done !== 1'b1 && n < 200) begin
         if (n < int'(FRAME_LEN) && tx !== exp_bits[n / CPB]) bad++;
         n++;
         @(negedge clk);
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL p07_pattern: %0d wrong line samples, required 0", bad);
      else pass_cnt++;
      check_cnt++;
      if (n !== int'(FRAME_LEN)) $display("FAIL p07_frame_len: got %0d cycles, required %0d", n, FRAME_LEN);
      else pass_cnt++;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes [0:2];
      int unsigned r0, d0;
      int n, bad, gap;
      bytes[0] = 8'h00;
      bytes[1] = 8'hFF;
      bytes[2] = 8'h55;
      r0 = rd_en_cnt;
      d0 = done_cnt;
      push(bytes[0]);
      push(bytes[1]);
      push(bytes[2]);
      for (int f = 0; f < 3; f++) begin
         build_frame(bytes[f]);
`ifdef UART_TX_PARITY_EN
         exp_bits[9] = 1'b0;
`endif
         gap = 0;
         while (tx !== 1'b0 && gap < 20) begin
            gap++;
            @(negedge clk);
         end
         check_cnt++;
         if (gap !== 3) $display("FAIL b2b_gap_%0d: got %0d high cycles, required 3", f, gap);
         else pass_cnt++;
         n = 0;
         bad = 0;
         while (tx_done !== 1'b1 && n < 200) begin
            if (n < int'(FRAME_LEN) && tx !== exp_bits[n / CPB]) bad++;
            n++;
            @(negedge clk);
         end
         check_cnt++;
         if (bad !== 0 || n !== int'(FRAME_LEN))
            $display("FAIL b2b_frame_%0d: %0d wrong samples, length %0d, required 0 and %0d",
                     f, bad, n, FRAME_LEN);
         else pass_cnt++;
      end
      @(negedge clk);
      check_cnt++;
      if (rd_en_cnt - r0 !== 3 || done_cnt - d0 !== 3)
         $display("FAIL b2b_counts: pops=%0d dones=%0d, required 3 and 3", rd_en_cnt - r0, done_cnt - d0);
      else pass_cnt++;
   endtask

   task automatic test_empty_idle;
      int unsigned r0;
      int bad = 0;
      r0 = rd_en_cnt;
      repeat (1000) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL empty_idle: %0d cycles not idle, required 0", bad);
      else pass_cnt++;
      check_cnt++;
      if (rd_en_cnt - r0 !== 0 || pop_empty_cnt !== 0)
         $display("FAIL empty_no_pop: pops=%0d pops_on_empty=%0d, required 0 and 0",
                  rd_en_cnt - r0, pop_empty_cnt);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame;
      int unsigned r0, d0;
      int wait_n;
      int bad = 0;
      r0 = rd_en_cnt;
      d0 = done_cnt;
      push(8'hA5);
      wait_n = 0;
      while (tx !== 1'b0 && wait_n < 10) begin
         wait_n++;
         @(negedge clk);
      end
      // sample 55 cycles after the fall lands mid data bit 4 (0 for 0xA5)
      repeat (55) @(negedge clk);
      check_cnt++;
      if (tx !== 1'b0 || busy !== 1'b1)
         $display("FAIL rst_mid_bit4: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      check_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0)
         $display("FAIL rst_mid_async: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check_cnt++;
      if (bad !== 0) $display("FAIL rst_mid_after_release: %0d cycles not idle, required 0", bad);
      else pass_cnt++;
      check_cnt++;
      if (rd_en_cnt - r0 !== 1 || done_cnt - d0 !== 0)
         $display("FAIL rst_mid_counts: pops=%0d dones=%0d, required 1 and 0", rd_en_cnt - r0, done_cnt - d0);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_parity;
      test_back_to_back;
      test_empty_idle;
      test_reset_mid_frame;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1);
   end

endmodule
